unsigned_product_accumulator: RTL

//  Downstream stage of unsigned_multiply: consumes its 2*WIDTH-bit unsigned product

---
 rtl/unsigned_product_accumulator_if.sv | 24 ++
 rtl/unsigned_product_accumulator.sv | 78 +++++++
 2 files changed

// File: rtl/unsigned_product_accumulator_if.sv
// Valid/ready bundle between the product stream source, the accumulator and the sum sink.
// The master drives products and out_ready; the slave is the accumulator.
interface unsigned_product_accumulator_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20
);
  logic [2*WIDTH-1:0]   product_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_WIDTH-1:0] sum_out;
  logic                 overflow;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output product_in, in_valid, out_ready,
    input  in_ready, sum_out, overflow, out_valid
  );

  modport slave (
    input  product_in, in_valid, out_ready,
    output in_ready, sum_out, overflow, out_valid
  );
endinterface

// File: rtl/unsigned_product_accumulator.sv
// Sums COUNT consecutive unsigned products into one ACC_WIDTH-bit result with a sticky
// carry-out flag, then holds it on a valid/ready output until the sink takes it.
module unsigned_product_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned COUNT     = 4,
  parameter int unsigned ACC_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  unsigned_product_accumulator_if.slave bus
);
  localparam int unsigned CntW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] sum_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ovf_acc_q;
  logic                 overflow_q;

  logic [ACC_WIDTH:0]   add_d;
  logic                 last_d;

  // Extra top bit captures the carry out of ACC_WIDTH.
  assign add_d  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, bus.product_in};
  assign last_d = (cnt_q == CntW'(COUNT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      // Partial sum and any pending result are dropped; sum_out keeps its last value.
      state_q   <= StAccum;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (bus.in_valid) begin
            if (last_d) begin
              sum_q      <= add_d[ACC_WIDTH-1:0];
              overflow_q <= ovf_acc_q | add_d[ACC_WIDTH];
              state_q    <= StDone;
              acc_q      <= '0;
              cnt_q      <= '0;
              ovf_acc_q  <= 1'b0;
            end else begin
              acc_q     <= add_d[ACC_WIDTH-1:0];
              ovf_acc_q <= ovf_acc_q | add_d[ACC_WIDTH];
              cnt_q     <= cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  // Handshake outputs decode the state flop only, so there is no input-to-output path.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum_out   = sum_q;
  assign bus.overflow  = overflow_q;
endmodule
